exe_stage: RTL



---
 rtl/arm_pkg.sv | 55 +++++
 rtl/exe_mul_seq.sv | 71 +++++++
 rtl/exe_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: ALU command codes, shift types, forward selects,
// multiplier FSM states and small datapath helpers.
package arm_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                input logic [4:0] n);
        logic [2*DATA_W-1:0] d;
        d = {x, x} >> n;
        return d[DATA_W-1:0];
    endfunction

    // Encoding 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] rv,
                                                  input logic [DATA_W-1:0] mv,
                                                  input logic [DATA_W-1:0] wv);
        logic [DATA_W-1:0] r;
        case (sel)
            FWD_MEM: r = mv;
            FWD_WB:  r = wv;
            default: r = rv;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low word kept.
// Only instantiated when EXE_MUL_EN is defined.
module exe_mul_seq
    import arm_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic              load, last_step;

    assign load      = (state_q == MUL_IDLE) && start;
    assign last_step = (cnt_q == CNT_W'(MUL_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MUL_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start)     state_d = MUL_BUSY;
            MUL_BUSY: if (last_step) state_d = MUL_DONE;
            MUL_DONE:                state_d = MUL_IDLE;
            default:                 state_d = MUL_IDLE;
        endcase
    end

    // Stall is raised in the issue cycle itself so the hazard unit freezes IF/ID at once;
    // it is forced low while reset is held so the front end never sees a stuck stall.
    always_comb begin
        stall = !rst && (load || (state_q == MUL_BUSY));
        done  = (state_q == MUL_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt_q <= '0;
        else if (load)                  cnt_q <= '0;
        else if (state_q == MUL_BUSY)   cnt_q <= cnt_q + CNT_W'(1);
    end

    // Operands are captured once at issue; later forwarding changes cannot leak in.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
        end else if (state_q == MUL_BUSY) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, Val2 generation, ALU, branch target and NZCV.
// Define EXE_MUL_EN to build the iterative multiplier and the MUL command.
module exe_stage
    import arm_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  exe_cmd,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm_24,
    input  logic [3:0]  dest_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd,
    input  logic [31:0] wb_fwd,
    output logic [31:0] alu_res,
    output logic [31:0] store_data,
    output logic [31:0] br_addr,
    output logic        b_taken,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [3:0]  dest,
    output logic [3:0]  sr,
    output logic        stall
);

    logic [31:0]        op_a, rm_val, val2, b_eff, res;
    logic signed [31:0] rm_s;
    logic signed [31:0] br_off;
    logic [32:0]        sum;
    logic [4:0]         shamt;
    logic               cin, arith, nz_we, cv_we, c_new, v_new;
    logic [3:0]         sr_next;
    logic               mul_done;
    logic [31:0]        mul_product;

    assign op_a       = fwd_mux(sel_src1, val_rn, mem_fwd, wb_fwd);
    assign rm_val     = fwd_mux(sel_src2, val_rm, mem_fwd, wb_fwd);
    assign rm_s       = rm_val;
    assign store_data = rm_val;
    assign shamt      = shift_operand[11:7];

    always_comb begin
        val2 = '0;
        if (mem_r_en_in || mem_w_en_in) begin
            val2 = {20'd0, shift_operand};
        end else if (imm_in) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = rm_val << shamt;
                SH_LSR:  val2 = rm_val >> shamt;
                SH_ASR:  val2 = 32'(rm_s >>> shamt);
                default: val2 = ror32(rm_val, shamt);
            endcase
        end
    end

    function automatic logic add_ovf(input logic a31, input logic b31, input logic r31);
        return (a31 == b31) && (r31 != a31);
    endfunction

    // Subtraction runs through the same adder as A + ~B + carry-in, so C is NOT borrow.
    always_comb begin
        res   = '0;
        b_eff = val2;
        cin   = 1'b0;
        arith = 1'b0;
        nz_we = 1'b0;
        cv_we = 1'b0;
        case (exe_cmd)
            CMD_MOV: begin res = val2;        nz_we = 1'b1; end
            CMD_MVN: begin res = ~val2;       nz_we = 1'b1; end
            CMD_AND: begin res = op_a & val2; nz_we = 1'b1; end
            CMD_ORR: begin res = op_a | val2; nz_we = 1'b1; end
            CMD_EOR: begin res = op_a ^ val2; nz_we = 1'b1; end
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = sr[1]; end
            CMD_SUB: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b_eff = ~val2; cin = sr[1]; end
`ifdef EXE_MUL_EN
            CMD_MUL: begin res = mul_done ? mul_product : '0; nz_we = mul_done; end
`endif
            default: res = '0;
        endcase
        sum   = {1'b0, op_a} + {1'b0, b_eff} + {32'd0, cin};
        c_new = sum[32];
        v_new = add_ovf(op_a[31], b_eff[31], sum[31]);
        if (arith) begin
            res   = sum[31:0];
            nz_we = 1'b1;
            cv_we = 1'b1;
        end
    end

    assign alu_res = res;
    assign sr_next = {nz_we ? res[31]      : sr[3],
                      nz_we ? (res == '0)  : sr[2],
                      cv_we ? c_new        : sr[1],
                      cv_we ? v_new        : sr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                sr <= 4'b0000;
        else if (s_in && !stall) sr <= sr_next;
    end

    assign br_off   = 32'($signed(signed_imm_24));
    assign br_addr  = pc_in + 32'(br_off <<< 2);
    assign b_taken  = b_in;
    assign wb_en    = wb_en_in;
    assign mem_r_en = mem_r_en_in;
    assign mem_w_en = mem_w_en_in;
    assign dest     = dest_in;

`ifdef EXE_MUL_EN
    logic mul_start;
    assign mul_start = (exe_cmd == CMD_MUL);

    exe_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (val2),
        .stall   (stall),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic mul_unused;
    assign stall       = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign mul_unused  = (MUL_CYCLES == 0) ^ mul_done ^ (^mul_product);
`endif

endmodule
